mem2_stage: RTL and testbench

//  Second memory stage of the RV32I pipeline, directly downstream of MEM1. Registers mem12mem2_bus,

---
 rtl/mem2_stage_pkg.sv | 74 +++++++
 rtl/mem2_stage_if.sv | 31 +++
 rtl/mem2_load_align.sv | 44 ++++
 rtl/mem2_stage.sv | 84 ++++++++
 tb/tb_mem2_stage.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem2_stage_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : mem2_stage_pkg                                                  |
// | Purpose  : Shared widths, stall-vector bit positions, load funct3 codes    |
// |            and packed bus layouts for the MEM2 pipeline stage.             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package mem2_stage_pkg;

   // Bus widths of the three stage-boundary buses
   localparam int MEM12MEM2_WD = 142;
   localparam int MEM22WB_WD   = 71;
   localparam int MEM22ID_WD   = 38;

   // Global stall vector: one bit per pipeline stage
   localparam int STALL_WD = 6;
   localparam int ST_IF    = 0;
   localparam int ST_ID    = 1;
   localparam int ST_EX    = 2;
   localparam int ST_MEM1  = 3;
   localparam int ST_MEM2  = 4;
   localparam int ST_WB    = 5;

   // RV32I load funct3 encodings; the remaining codes fall back to a word load
   typedef enum logic [2:0] {
      F3_LB  = 3'b000,
      F3_LH  = 3'b001,
      F3_LW  = 3'b010,
      F3_LBU = 3'b100,
      F3_LHU = 3'b101
   } load_f3_e;

   // MEM1 -> MEM2 bus, MSB first: valid, pc, rd_we, rd, is_load, funct3, addr_lo, result, rdata
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic        rd_we;
      logic [4:0]  rd;
      logic        is_load;
      logic [2:0]  funct3;
      logic [2:0]  addr_lo;
      logic [31:0] result;
      logic [63:0] rdata;
   } mem12mem2_t;

   // MEM2 -> WB bus
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic        rd_we;
      logic [4:0]  rd;
      logic [31:0] wdata;
   } mem22wb_t;

   // MEM2 -> ID bypass bus
   typedef struct packed {
      logic        rd_we;
      logic [4:0]  rd;
      logic [31:0] wdata;
   } mem22id_t;

   // The bypass carries exactly the register-write part of the write-back bus
   function automatic mem22id_t wb_to_id(input mem22wb_t wb);
      mem22id_t id;
      id.rd_we = wb.rd_we;
      id.rd    = wb.rd;
      id.wdata = wb.wdata;
      return id;
   endfunction

endpackage : mem2_stage_pkg

`default_nettype wire

// File: rtl/mem2_stage_if.sv
// +----------------------------------------------------------------------------+
// | Module   : mem2_stage_if                                                   |
// | Purpose  : Bundles the MEM1->MEM2 input bus and the MEM2->WB / MEM2->ID    |
// |            output buses. 'slave' is the stage view, 'master' the          |
// |            upstream/environment view.                                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

interface mem2_stage_if;
   import mem2_stage_pkg::*;

   mem12mem2_t mem12mem2_bus;
   mem22wb_t   mem22wb_bus;
   mem22id_t   mem22id_bus;

   modport master (
      output mem12mem2_bus,
      input  mem22wb_bus,
      input  mem22id_bus
   );

   modport slave (
      input  mem12mem2_bus,
      output mem22wb_bus,
      output mem22id_bus
   );

endinterface : mem2_stage_if

`default_nettype wire

// File: rtl/mem2_load_align.sv
// +----------------------------------------------------------------------------+
// | Module   : mem2_load_align                                                 |
// | Purpose  : Picks the addressed byte/half/word out of the 64-bit SRAM       |
// |            doubleword and sign- or zero-extends it to 32 bits.            |
// |            Misaligned half/word offsets are aligned down.                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem2_load_align
   import mem2_stage_pkg::*;
(
   input  wire  [63:0] i_rdata,
   input  wire  [2:0]  i_funct3,
   input  wire  [2:0]  i_addr_lo,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_word;

   // Lane selection: byte uses all offset bits, half drops bit 0, word keeps only bit 2
   always_comb begin
      w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
      w_half = i_rdata[{i_addr_lo[2:1], 4'b0000} +: 16];
      w_word = i_rdata[{i_addr_lo[2], 5'b00000} +: 32];
   end

   // Extension by load type; reserved funct3 codes behave as LW
   always_comb begin
      o_data = w_word;
      case (i_funct3)
         F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
         F3_LBU:  o_data = {24'd0, w_byte};
         F3_LH:   o_data = {{16{w_half[15]}}, w_half};
         F3_LHU:  o_data = {16'd0, w_half};
         default: o_data = w_word;
      endcase
   end

endmodule : mem2_load_align

`default_nettype wire

// File: rtl/mem2_stage.sv
// +----------------------------------------------------------------------------+
// | Module   : mem2_stage                                                      |
// | Purpose  : Second memory stage of the RV32I pipeline. Registers the MEM1   |
// |            bus, extracts load data, drives the write-back bus and an       |
// |            optional bypass bus to ID. Obeys global stall and flush.        |
// | Config   : MEM2_FWD_EN - when defined, the ID bypass bus is driven;        |
// |            otherwise it is tied to zero.                                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem2_stage
   import mem2_stage_pkg::*;
(
   input wire                clk,
   input wire                rst_n,
   input wire                flush,
   input wire [STALL_WD-1:0] stall,
   mem2_stage_if.slave       bus
);

   mem12mem2_t  r_stage;
   logic [31:0] w_load_data;
   logic [31:0] w_wdata;
   logic        w_rd_we;
   mem22wb_t    w_wb;
   logic        w_unused_stall;

   // Stage register: flush beats a MEM2 hold, a MEM2 hold beats a MEM1 bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stage <= '0;
      end else if (flush) begin
         r_stage <= '0;
      end else if (stall[ST_MEM2]) begin
         r_stage <= r_stage;
      end else if (stall[ST_MEM1]) begin
         r_stage <= '0;
      end else begin
         r_stage <= bus.mem12mem2_bus;
      end
   end

   mem2_load_align u_load_align (
      .i_rdata   (r_stage.rdata),
      .i_funct3  (r_stage.funct3),
      .i_addr_lo (r_stage.addr_lo),
      .o_data    (w_load_data)
   );

   // Write data: aligned load data for loads, ALU result otherwise
   always_comb begin
      w_wdata = r_stage.result;
      if (r_stage.is_load) begin
         w_wdata = w_load_data;
      end
   end

   assign w_rd_we = r_stage.valid & r_stage.rd_we;

   // Write-back bus packed purely from the stage register (no input-to-output path)
   always_comb begin
      w_wb       = '0;
      w_wb.valid = r_stage.valid;
      w_wb.pc    = r_stage.pc;
      w_wb.rd_we = w_rd_we;
      w_wb.rd    = r_stage.rd;
      w_wb.wdata = w_wdata;
   end

   assign bus.mem22wb_bus = w_wb;

`ifdef MEM2_FWD_EN
   assign bus.mem22id_bus = wb_to_id(w_wb);
`else
   assign bus.mem22id_bus = '0;
`endif

   // Stall bits belonging to other stages are not used here
   assign w_unused_stall = ^{stall[ST_WB], stall[ST_EX:ST_IF]};

endmodule : mem2_stage

`default_nettype wire

// File: tb/tb_mem2_stage.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_mem2_stage                                                   |
// | Purpose  : Self-checking bench for mem2_stage: reference model feeds a     |
// |            scoreboard queue, a negedge monitor pops and compares.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_mem2_stage;
   import mem2_stage_pkg::*;

   typedef struct packed {
      logic [70:0] wb;
      logic [37:0] id;
   } exp_t;

   logic                clk   = 1'b0;
   logic                rst_n = 1'b0;
   logic                flush = 1'b0;
   logic [STALL_WD-1:0] stall = '0;

   mem2_stage_if u_if ();

   mem2_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .stall (stall),
      .bus   (u_if)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_errors = 0;
   exp_t       q[$];
   mem12mem2_t m_state = '0;

   task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference load result computed with shifts and masks on whole values
   function automatic logic [31:0] ref_wdata(input mem12mem2_t s);
      longint unsigned bytev;
      longint unsigned halfv;
      longint unsigned wordv;
      if (!s.is_load) return s.result;
      bytev = (s.rdata >> (8 * s.addr_lo)) & 64'hFF;
      halfv = (s.rdata >> (16 * (s.addr_lo / 2))) & 64'hFFFF;
      wordv = (s.rdata >> (32 * (s.addr_lo / 4))) & 64'hFFFF_FFFF;
      case (s.funct3)
         3'd0:    return (bytev >= 128) ? (32'(bytev) | 32'hFFFF_FF00) : 32'(bytev);
         3'd4:    return 32'(bytev);
         3'd1:    return (halfv >= 32768) ? (32'(halfv) | 32'hFFFF_0000) : 32'(halfv);
         3'd5:    return 32'(halfv);
         default: return 32'(wordv);
      endcase
   endfunction

   function automatic exp_t ref_out(input mem12mem2_t s);
      exp_t        e;
      logic [31:0] wd;
      logic        we;
      wd   = ref_wdata(s);
      we   = s.valid & s.rd_we;
      e.wb = {s.valid, s.pc, we, s.rd, wd};
`ifdef MEM2_FWD_EN
      e.id = {we, s.rd, wd};
`else
      e.id = '0;
`endif
      return e;
   endfunction

   function automatic mem12mem2_t mk(input logic [31:0] pc, input logic [4:0] rd,
                                     input logic ld, input logic [2:0] f3,
                                     input logic [2:0] a, input logic [31:0] res,
                                     input logic [63:0] d);
      mem12mem2_t m;
      m.valid = 1'b1; m.pc = pc; m.rd_we = 1'b1; m.rd = rd; m.is_load = ld;
      m.funct3 = f3; m.addr_lo = a; m.result = res; m.rdata = d;
      return m;
   endfunction

   function automatic mem12mem2_t rand_instr();
      mem12mem2_t m;
      m.valid   = ($urandom_range(0, 7) != 0);
      m.pc      = $urandom;
      m.rd_we   = 1'($urandom_range(0, 1));
      m.rd      = 5'($urandom_range(0, 31));
      m.is_load = 1'($urandom_range(0, 1));
      m.funct3  = 3'($urandom_range(0, 7));
      m.addr_lo = 3'($urandom_range(0, 7));
      m.result  = $urandom;
      m.rdata   = {$urandom, $urandom};
      return m;
   endfunction

   function automatic logic [STALL_WD-1:0] stb(input logic m1, input logic m2);
      logic [STALL_WD-1:0] s;
      s = '0;
      s[ST_MEM1] = m1;
      s[ST_MEM2] = m2;
      return s;
   endfunction

   // Apply one cycle of stimulus; the model's stage content is what the DUT must show after the edge
   task automatic drive(input mem12mem2_t in, input logic fl, input logic [STALL_WD-1:0] st);
      u_if.mem12mem2_bus = in;
      flush = fl;
      stall = st;
      if (fl) begin
         m_state = '0;
      end else if (!st[ST_MEM2]) begin
         if (st[ST_MEM1]) m_state = '0;
         else             m_state = in;
      end
      @(posedge clk);
      q.push_back(ref_out(m_state));
      #1;
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         check("sb_wb", u_if.mem22wb_bus, e.wb);
         check("sb_id", 71'(u_if.mem22id_bus), 71'(e.id));
      end
   end

   initial begin
      mem12mem2_t          r;
      logic                fl;
      logic [STALL_WD-1:0] st;
      logic [37:0]         exp_id;

      u_if.mem12mem2_bus = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_wb", u_if.mem22wb_bus, '0);
      check("reset_id", 71'(u_if.mem22id_bus), '0);
      rst_n = 1'b1;

      // LB sign extension of byte 5
      drive(mk(32'h100, 5'd3, 1'b1, 3'b000, 3'd5, 32'h0, 64'h0000_8000_0000_0000), 1'b0, '0);
      check("lb_wdata", 71'(u_if.mem22wb_bus.wdata), 71'(32'hFFFF_FF80));
      check("lb_rd_we", 71'(u_if.mem22wb_bus.rd_we), 71'(1'b1));

      // LHU top half, LW high word
      drive(mk(32'h104, 5'd4, 1'b1, 3'b101, 3'd6, 32'h0, 64'hBEEF_0000_0000_0000), 1'b0, '0);
      check("lhu_wdata", 71'(u_if.mem22wb_bus.wdata), 71'(32'h0000_BEEF));
      drive(mk(32'h108, 5'd5, 1'b1, 3'b010, 3'd4, 32'h0, 64'h0000_BEEF_0000_0000), 1'b0, '0);
      check("lw_wdata", 71'(u_if.mem22wb_bus.wdata), 71'(32'h0000_BEEF));

      // ALU result held across three MEM2 stall cycles
      drive(mk(32'h10C, 5'd9, 1'b0, 3'b000, 3'd0, 32'h1234, 64'h0), 1'b0, '0);
      check("alu_wdata", 71'(u_if.mem22wb_bus.wdata), 71'(32'h1234));
      for (int i = 0; i < 3; i++) begin
         drive(rand_instr(), 1'b0, stb(1'b0, 1'b1));
         check("hold_wdata", 71'(u_if.mem22wb_bus.wdata), 71'(32'h1234));
         check("hold_pc", 71'(u_if.mem22wb_bus.pc), 71'(32'h10C));
      end
      drive(mk(32'h110, 5'd10, 1'b0, 3'b000, 3'd0, 32'h5678, 64'h0), 1'b0, '0);
      check("after_hold", 71'(u_if.mem22wb_bus.wdata), 71'(32'h5678));

      // MEM1 stall alone inserts a bubble; flush with both stalls also bubbles
      drive(mk(32'h114, 5'd11, 1'b0, 3'b000, 3'd0, 32'h9, 64'h0), 1'b0, stb(1'b1, 1'b0));
      check("mem1_bubble", 71'(u_if.mem22wb_bus.valid), 71'(1'b0));
      drive(mk(32'h118, 5'd12, 1'b0, 3'b000, 3'd0, 32'hA, 64'h0), 1'b0, '0);
      drive(mk(32'h11C, 5'd13, 1'b0, 3'b000, 3'd0, 32'hB, 64'h0), 1'b1, stb(1'b1, 1'b1));
      check("flush_bubble", u_if.mem22wb_bus, '0);

      // Bypass bus
      drive(mk(32'h120, 5'd7, 1'b0, 3'b000, 3'd0, 32'hA5, 64'h0), 1'b0, '0);
`ifdef MEM2_FWD_EN
      exp_id = {1'b1, 5'd7, 32'hA5};
`else
      exp_id = '0;
`endif
      check("bypass", 71'(u_if.mem22id_bus), 71'(exp_id));

      // Asynchronous reset mid-cycle clears outputs immediately
      #2;
      rst_n = 1'b0;
      q.delete();
      m_state = '0;
      #1;
      check("async_rst_wb", u_if.mem22wb_bus, '0);
      check("async_rst_id", 71'(u_if.mem22id_bus), '0);
      @(posedge clk);
      #1;
      check("rst_hold_wb", u_if.mem22wb_bus, '0);
      rst_n = 1'b1;

      // Randomized traffic with occasional stalls, flushes and noise on other stall bits
      for (int i = 0; i < 400; i++) begin
         r  = rand_instr();
         fl = ($urandom_range(0, 9) == 0);
         st = STALL_WD'($urandom_range(0, (1 << STALL_WD) - 1));
         st[ST_MEM1] = ($urandom_range(0, 4) == 0);
         st[ST_MEM2] = ($urandom_range(0, 4) == 0);
         drive(r, fl, st);
      end

      @(negedge clk);
      #1;
      check("sb_drain", 71'(q.size()), '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_mem2_stage

`default_nettype wire
